execute_stage_mdu: RTL and testbench
====================================

Name: execute_stage_mdu

Overview:
- Parametrised next-generation RV32/RV64 execute stage for the 5-stage pipeline. It sits between the ID/EX and EX/MEM boundaries.
- Provides operand forwarding, a single-cycle integer ALU, branch flags, and an iterative unsigned multiply/divide unit (MDU).
- The MDU stalls upstream through a busy handshake.
- Contains the EX/MEM pipeline register, with valid, stall and flush.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- REG_AW, 5, register-address width.
- PC_W, 32, width of the PC+4 carried to MEM.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- valid_e  in  1  EX holds a live instruction.
- flush_e  in  1  kill the EX instruction, including an MDU op in flight.
- stall_m  in  1  MEM cannot accept; EX/MEM register holds.
- reg_write_e, mem_write_e  in  1 each  control bits from ID/EX.
- result_src_e  in  2  result select; 2'b11 = pass immediate (LUI).
- alu_control_e  in  4  operation code, see Behaviour.
- alu_src_e  in  1  0 = forwarded rs2, 1 = imm_ext_e.
- rd1_e, rd2_e, imm_ext_e  in  XLEN each  operands.
- rd_e  in  REG_AW  destination register.
- pc_plus4_e  in  PC_W  carried to MEM.
- forward_a_e, forward_b_e  in  2 each  00 = RF value, 01 = alu_result_m, 10 = result_w, 11 = RF value.
- result_w  in  XLEN  writeback-stage result used for forwarding.
- busy_e  out  1  EX must hold; ID/EX and PC stall.
- zero_e, neg_e  out  1 each  ALU result == 0, ALU result MSB (single-cycle ops only).
- valid_m, reg_write_m, mem_write_m  out  1 each  EX/MEM register outputs.
- result_src_m  out  2  EX/MEM register output.
- alu_result_m, write_data_m  out  XLEN each  EX result; forwarded rs2 for stores.
- rd_m  out  REG_AW  EX/MEM register output.
- pc_plus4_m  out  PC_W  EX/MEM register output.

Behaviour:
- Forwarding is applied to rs1 and rs2 before the alu_src mux. write_data_m is the forwarded rs2, never the immediate.
- ALU ops, all combinational:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 1001 sltu.
  - 0110 sra, 0111 srl, 1000 sll; shift amount is B[$clog2(XLEN)-1:0].
  - 1010, 1011 → 0.
  - 1100 MUL (low XLEN), 1101 MULHU (high XLEN), 1110 DIVU, 1111 REMU.
- EX result is imm_ext_e when result_src_e == 2'b11, otherwise the ALU/MDU result.
- MDU FSM has three states, IDLE, BUSY and DONE:
  - IDLE: if valid_e & op[3:2]==2'b11 & !flush_e, latch A, B and the op; count←0; go to BUSY. busy_e = 1 in this same cycle (combinational).
  - BUSY: one shift-add (mul) or restoring-subtract (div) iteration per cycle. busy_e = 1. After XLEN iterations go to DONE.
  - DONE: busy_e = 0 and the MDU result drives the EX result. If !stall_m, the EX/MEM register captures it and the FSM goes to IDLE; else the FSM stays in DONE.
- Latency: an MDU op accepted at cycle T appears on alu_result_m after the edge ending cycle T+XLEN+1. For XLEN=32 that is 34 cycles in EX.
- Operands are latched at accept time, so changes to the forwarding inputs during BUSY are ignored.
- Divide by zero: DIVU → all ones; REMU → dividend. No trap.
- EX/MEM register:
  - if stall_m: hold all outputs.
  - else if flush_e or busy_e or !valid_e: insert a bubble: valid_m = reg_write_m = mem_write_m = 0; data fields don't-care but deterministic (zero).
  - else: capture.
- flush_e in BUSY or DONE: FSM goes to IDLE next cycle, and no result is written.
- Reset (reset = 0): FSM to IDLE, counter to 0, and every output register to 0, including in the middle of an operation. Combinational outputs follow the zeroed state.
- stall_m and flush_e asserted together: flush wins for the FSM; the EX/MEM register holds.

Decomposition:
- Shared package exe_pkg holds:
  - ALU op codes.
  - Forward-select and result_src encodings.
  - MDU state enum {IDLE, BUSY, DONE}.
- One sub-module, mdu_iter (parameter XLEN), containing the iterative multiplier/divider, counter and FSM. Its interface is start, op, a, b, flush, hold in; busy, done, result out.
- The ALU and forwarding muxes stay inline.

Test Plan:
- Reset held low for 3 cycles, then MUL launched and reset asserted at BUSY cycle 10 → all outputs 0, busy_e = 0 the cycle after reset is sampled.
- ADD, rd1 = 5, forward_a = 01, alu_result_m = 20, rd2 = 3 → alu_result_m = 23 one cycle later, valid_m = 1.
- SW with alu_src = 1, imm = 8, forward_b = 10, result_w = 0xDEAD → write_data_m = 0xDEAD, mem_write_m = 1.
- MUL 7×6 at cycle T → busy_e high for T..T+32; alu_result_m = 42 after cycle T+33; bubbles (valid_m = 0) in between. MULHU 0xFFFFFFFF×2 → 1.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- flush_e at BUSY cycle 5 → busy_e drops next cycle, no valid_m for that op. Separately, stall_m held 3 cycles during DONE → result held, then captured once.

Source files
------------

// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage:
//   - ALU / MDU operation codes (alu_control_e encoding)
//   - forwarding-select and result_src encodings
//   - MDU controller state enum
//   - helper that classifies an operation code as an MDU op
// -----------------------------------------------------------------------------
package exe_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1100;
    localparam logic [3:0] ALU_MULHU = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    // Forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_RF2 = 2'b11;

    // result_src value that passes the immediate (LUI)
    localparam logic [1:0] RES_IMM = 2'b11;

    // MDU controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

    // Upper two opcode bits set means multiply/divide
    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/execute_stage_mdu_mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative unsigned multiply / divide unit, one bit per cycle, XLEN cycles.
//   clk, reset : clock, synchronous active-low reset
//   start      : request to accept a new op (only honoured in IDLE)
//   op         : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b       : operands, latched at accept
//   flush      : abandon any op in flight / block a new accept
//   hold       : downstream not ready, keep the finished result in DONE
//   busy       : combinational, high on accept cycle and throughout BUSY
//   done       : result valid
//   result     : selected half of the working register
// A single 2*XLEN working register serves both operations: for multiply it
// holds {accumulator, multiplier}, for divide {remainder, quotient}. The
// op[0] bit therefore simply selects the high or low half as the result.
// -----------------------------------------------------------------------------
module mdu_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_t        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] p_r, p_s;
    logic [XLEN-1:0]   opnd_r;      // multiplicand or divisor
    logic [1:0]        op_r;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic              accept_s;
    logic              last_s;

    assign accept_s = start & ~flush;
    assign last_s   = (cnt_r == CNT_W'(XLEN - 1));
    assign done     = (state_r == DONE);
    assign result   = op_r[0] ? p_r[2*XLEN-1:XLEN] : p_r[XLEN-1:0];

    // One shift-add or restoring-subtract iteration on the working register
    always_comb begin
        mul_sum_s   = {1'b0, p_r[2*XLEN-1:XLEN]}
                    + (p_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = p_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (op_r[1]) begin
            // Remainder stays below 2^k after k steps, so no borrow means fits
            if (!div_diff_s[XLEN]) begin
                p_s = {div_diff_s[XLEN-1:0], p_r[XLEN-2:0], 1'b1};
            end else begin
                p_s = {div_shift_s[XLEN-1:0], p_r[XLEN-2:0], 1'b0};
            end
        end else begin
            p_s = {mul_sum_s, p_r[XLEN-1:1]};
        end
    end

    // Controller next state and busy handshake
    always_comb begin
        state_s = state_r;
        busy    = 1'b0;
        case (state_r)
            IDLE: begin
                busy = accept_s;
                if (accept_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (flush) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (flush || !hold) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and operand/working registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            p_r     <= {(2*XLEN){1'b0}};
            opnd_r  <= {XLEN{1'b0}};
            op_r    <= 2'b00;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && accept_s) begin
                cnt_r <= {CNT_W{1'b0}};
                op_r  <= op;
                if (op[1]) begin
                    p_r    <= {{XLEN{1'b0}}, a};
                    opnd_r <= b;
                end else begin
                    p_r    <= {{XLEN{1'b0}}, b};
                    opnd_r <= a;
                end
            end else if (state_r == BUSY) begin
                p_r   <= p_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_stage_mdu.sv
// -----------------------------------------------------------------------------
// execute_stage_mdu
// Execute stage: operand forwarding, single-cycle ALU with branch flags,
// iterative multiply/divide (via mdu_iter) and the EX/MEM pipeline register.
//   clk, reset            : clock, synchronous active-low reset
//   valid_e, flush_e      : live instruction / kill it (incl. MDU in flight)
//   stall_m               : MEM not ready, EX/MEM register holds
//   control/data *_e      : ID/EX fields
//   forward_a/b_e         : 00/11 RF, 01 alu_result_m, 10 result_w
//   busy_e                : EX must hold (MDU accepting or iterating)
//   zero_e, neg_e         : flags of the single-cycle ALU result
//   *_m                   : EX/MEM register outputs
// -----------------------------------------------------------------------------
module execute_stage_mdu
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_e,
    input  logic              flush_e,
    input  logic              stall_m,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic [1:0]        result_src_e,
    input  logic [3:0]        alu_control_e,
    input  logic              alu_src_e,
    input  logic [XLEN-1:0]   rd1_e,
    input  logic [XLEN-1:0]   rd2_e,
    input  logic [XLEN-1:0]   imm_ext_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [PC_W-1:0]   pc_plus4_e,
    input  logic [1:0]        forward_a_e,
    input  logic [1:0]        forward_b_e,
    input  logic [XLEN-1:0]   result_w,
    output logic              busy_e,
    output logic              zero_e,
    output logic              neg_e,
    output logic              valid_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic [1:0]        result_src_m,
    output logic [XLEN-1:0]   alu_result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [REG_AW-1:0] rd_m,
    output logic [PC_W-1:0]   pc_plus4_m
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] src_a_s, src_b_s, alu_b_s, alu_res_s, ex_res_s, mdu_res_s;
    logic [SH_W-1:0] shamt_s;
    logic            is_mdu_s, mdu_start_s, mdu_done_s;

    assign is_mdu_s    = is_mdu_op(alu_control_e);
    // Gating with reset keeps busy_e low while the stage is being reset
    assign mdu_start_s = valid_e & is_mdu_s & reset;
    assign alu_b_s     = alu_src_e ? imm_ext_e : src_b_s;
    assign shamt_s     = alu_b_s[SH_W-1:0];
    assign zero_e      = (alu_res_s == {XLEN{1'b0}});
    assign neg_e       = alu_res_s[XLEN-1];

    // Forwarding muxes for rs1 and rs2
    always_comb begin
        case (forward_a_e)
            FWD_MEM: src_a_s = alu_result_m;
            FWD_WB:  src_a_s = result_w;
            default: src_a_s = rd1_e;
        endcase
        case (forward_b_e)
            FWD_MEM: src_b_s = alu_result_m;
            FWD_WB:  src_b_s = result_w;
            default: src_b_s = rd2_e;
        endcase
    end

    // Single-cycle ALU; MDU codes and reserved codes yield zero here
    always_comb begin
        case (alu_control_e)
            ALU_ADD:  alu_res_s = src_a_s + alu_b_s;
            ALU_SUB:  alu_res_s = src_a_s - alu_b_s;
            ALU_AND:  alu_res_s = src_a_s & alu_b_s;
            ALU_OR:   alu_res_s = src_a_s | alu_b_s;
            ALU_XOR:  alu_res_s = src_a_s ^ alu_b_s;
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(alu_b_s))};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (src_a_s < alu_b_s)};
            ALU_SRA:  alu_res_s = $unsigned($signed(src_a_s) >>> shamt_s);
            ALU_SRL:  alu_res_s = src_a_s >> shamt_s;
            ALU_SLL:  alu_res_s = src_a_s << shamt_s;
            default:  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // EX result select: immediate pass, finished MDU result, or ALU
    always_comb begin
        if (result_src_e == RES_IMM) begin
            ex_res_s = imm_ext_e;
        end else if (is_mdu_s && mdu_done_s) begin
            ex_res_s = mdu_res_s;
        end else begin
            ex_res_s = alu_res_s;
        end
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start_s),
        .op     (alu_control_e[1:0]),
        .a      (src_a_s),
        .b      (alu_b_s),
        .flush  (flush_e),
        .hold   (stall_m),
        .busy   (busy_e),
        .done   (mdu_done_s),
        .result (mdu_res_s)
    );

    // EX/MEM pipeline register: hold on stall, zeroed bubble, else capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            alu_result_m <= {XLEN{1'b0}};
            write_data_m <= {XLEN{1'b0}};
            rd_m         <= {REG_AW{1'b0}};
            pc_plus4_m   <= {PC_W{1'b0}};
        end else if (stall_m) begin
            valid_m      <= valid_m;
            reg_write_m  <= reg_write_m;
            mem_write_m  <= mem_write_m;
            result_src_m <= result_src_m;
            alu_result_m <= alu_result_m;
            write_data_m <= write_data_m;
            rd_m         <= rd_m;
            pc_plus4_m   <= pc_plus4_m;
        end else if (flush_e || busy_e || !valid_e) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            alu_result_m <= {XLEN{1'b0}};
            write_data_m <= {XLEN{1'b0}};
            rd_m         <= {REG_AW{1'b0}};
            pc_plus4_m   <= {PC_W{1'b0}};
        end else begin
            valid_m      <= 1'b1;
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
            alu_result_m <= ex_res_s;
            write_data_m <= src_b_s;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_plus4_e;
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_mdu
// Directed, self-checking bench for execute_stage_mdu (XLEN=32). Expected
// EX/MEM contents are queued when an instruction is driven and compared
// when the stage retires it. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_execute_stage_mdu;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, valid_e, flush_e, stall_m, reg_write_e, mem_write_e, alu_src_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, result_w, pc_plus4_e;
    logic [4:0]  rd_e;
    logic        busy_e, zero_e, neg_e, valid_m, reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
    logic [4:0]  rd_m;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cnt;

    always #5 clk = ~clk;

    execute_stage_mdu #(.XLEN(32), .REG_AW(5), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .flush_e(flush_e), .stall_m(stall_m),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
        .busy_e(busy_e), .zero_e(zero_e), .neg_e(neg_e), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        valid_e       = 1'b1;
        flush_e       = 1'b0;
        alu_control_e = op;
        rd1_e         = a;
        rd2_e         = b;
        rd_e          = rd;
        alu_src_e     = 1'b0;
        forward_a_e   = FWD_RF;
        forward_b_e   = FWD_RF;
        result_src_e  = 2'b00;
        reg_write_e   = 1'b1;
        mem_write_e   = 1'b0;
        pc_plus4_e    = pc_plus4_e + 32'd4;
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] wd, input logic rw,
                        input logic mw, input logic [1:0] rs);
        exp_t e;
        e.res = res; e.wd = wd; e.rd = rd_e; e.rw = rw; e.mw = mw; e.rs = rs; e.pc = pc_plus4_e;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid_m"}, 64'(valid_m), 64'd1);
            chk({tag, "_result"}, 64'(alu_result_m), 64'(e.res));
            chk({tag, "_wdata"}, 64'(write_data_m), 64'(e.wd));
            chk({tag, "_rd"}, 64'(rd_m), 64'(e.rd));
            chk({tag, "_reg_write"}, 64'(reg_write_m), 64'(e.rw));
            chk({tag, "_mem_write"}, 64'(mem_write_m), 64'(e.mw));
            chk({tag, "_result_src"}, 64'(result_src_m), 64'(e.rs));
            chk({tag, "_pc4"}, 64'(pc_plus4_m), 64'(e.pc));
        end
    endtask

    task automatic bubble_check(input string tag);
        chk({tag, "_valid_m"}, 64'(valid_m), 64'd0);
        chk({tag, "_reg_write_m"}, 64'(reg_write_m), 64'd0);
        chk({tag, "_mem_write_m"}, 64'(mem_write_m), 64'd0);
    endtask

    task automatic alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string tag);
        set_instr(op, a, b, rd_e + 5'd1);
        push(exp, b, 1'b1, 1'b0, 2'b00);
        #1;
        chk({tag, "_zero"}, 64'(zero_e), 64'(exp == 32'd0));
        chk({tag, "_neg"}, 64'(neg_e), 64'(exp[31]));
        @(negedge clk);
        pop_check(tag);
    endtask

    // Count cycles with busy_e high (accept cycle already counted); bounded
    task automatic mdu_wait(output int n);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_e) break;
            n++;
            bubble_check("mdu_bubble");
            if (i == 3) rd1_e = ~rd1_e;   // operand change during BUSY must be ignored
        end
    endtask

    task automatic mdu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string tag);
        int n;
        set_instr(op, a, b, rd_e + 5'd1);
        push(exp, b, 1'b1, 1'b0, 2'b00);
        #1;
        chk({tag, "_busy_at_accept"}, 64'(busy_e), 64'd1);
        mdu_wait(n);
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        @(negedge clk);
        pop_check(tag);
        valid_e = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; valid_e = 1'b0; flush_e = 1'b0; stall_m = 1'b0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; alu_src_e = 1'b0;
        result_src_e = 2'b00; forward_a_e = 2'b00; forward_b_e = 2'b00;
        alu_control_e = 4'b0000; rd1_e = 32'd0; rd2_e = 32'd0; imm_ext_e = 32'd0;
        result_w = 32'd0; pc_plus4_e = 32'h1000; rd_e = 5'd0;

        // Reset held low for 3 rising edges
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_e), 64'd0);
        bubble_check("rst");
        chk("rst_result", 64'(alu_result_m), 64'd0);
        chk("rst_wdata", 64'(write_data_m), 64'd0);
        chk("rst_rd", 64'(rd_m), 64'd0);
        chk("rst_pc4", 64'(pc_plus4_m), 64'd0);
        reset = 1'b1;

        // Producer, then consumer forwarding from MEM
        alu_step(ALU_ADD, 32'd20, 32'd0, 32'd20, "add20");
        set_instr(ALU_ADD, 32'd5, 32'd3, 5'd3);
        forward_a_e = FWD_MEM;
        push(32'd23, 32'd3, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        pop_check("add_fwd_mem");

        // Store: immediate address offset, store data forwarded from WB
        set_instr(ALU_ADD, 32'h100, 32'h1234, 5'd0);
        alu_src_e = 1'b1; imm_ext_e = 32'd8; forward_b_e = FWD_WB; result_w = 32'hDEAD;
        reg_write_e = 1'b0; mem_write_e = 1'b1;
        push(32'h108, 32'hDEAD, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        pop_check("sw_fwd_wb");

        // LUI passes the immediate
        set_instr(ALU_ADD, 32'd7, 32'd9, 5'd4);
        result_src_e = RES_IMM; imm_ext_e = 32'h12345000;
        push(32'h12345000, 32'd9, 1'b1, 1'b0, RES_IMM);
        @(negedge clk);
        pop_check("lui");

        alu_step(ALU_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, "sub");
        alu_step(ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, "and");
        alu_step(ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, "or");
        alu_step(ALU_XOR,  32'h0000A5A5, 32'h0000FFFF, 32'h00005A5A, "xor");
        alu_step(ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        "slt");
        alu_step(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        "sltu");
        alu_step(ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, "sra");
        alu_step(ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, "srl");
        alu_step(4'b1010,  32'd3,        32'd4,        32'd0,        "op1010");
        alu_step(4'b1011,  32'd3,        32'd4,        32'd0,        "op1011");
        alu_step(ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        "add_wrap");
        alu_step(ALU_SLL,  32'd1,        32'h0000003F, 32'h80000000, "sll_shamt");

        // Reset in the middle of a MUL (EX/MEM held by stall so it is non-zero)
        set_instr(ALU_MUL, 32'd3, 32'd4, 5'd9);
        stall_m = 1'b1;
        #1;
        chk("rstmid_busy_accept", 64'(busy_e), 64'd1);
        repeat (10) @(negedge clk);
        chk("rstmid_busy_cycle10", 64'(busy_e), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 64'(busy_e), 64'd0);
        bubble_check("rstmid");
        chk("rstmid_result", 64'(alu_result_m), 64'd0);
        chk("rstmid_wdata", 64'(write_data_m), 64'd0);
        chk("rstmid_rd", 64'(rd_m), 64'd0);
        chk("rstmid_pc4", 64'(pc_plus4_m), 64'd0);
        chk("rstmid_rsrc", 64'(result_src_m), 64'd0);
        reset = 1'b1; valid_e = 1'b0; stall_m = 1'b0;
        @(negedge clk);

        // Multiply / divide including divide by zero
        mdu_step(ALU_MUL,   32'd7,        32'd6, 32'd42,       "mul");
        mdu_step(ALU_MULHU, 32'hFFFFFFFF, 32'd2, 32'd1,        "mulhu");
        mdu_step(ALU_DIVU,  32'd100,      32'd7, 32'd14,       "divu");
        mdu_step(ALU_REMU,  32'd100,      32'd7, 32'd2,        "remu");
        mdu_step(ALU_DIVU,  32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, "divu_by0");
        mdu_step(ALU_REMU,  32'd9,        32'd0, 32'd9,        "remu_by0");

        // Flush at BUSY cycle 5: no result retired
        set_instr(ALU_DIVU, 32'd50, 32'd5, 5'd12);
        repeat (5) @(negedge clk);
        chk("flush_busy_before", 64'(busy_e), 64'd1);
        flush_e = 1'b1;
        @(negedge clk);
        chk("flush_busy_after", 64'(busy_e), 64'd0);
        bubble_check("flush_edge");
        flush_e = 1'b0; valid_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bubble_check("flush_after");
        end
        chk("flush_sb_empty", 64'(sb_q.size()), 64'd0);

        // Stall held 3 cycles in DONE: result held back, then captured once
        set_instr(ALU_MUL, 32'd9, 32'd9, 5'd13);
        push(32'd81, 32'd9, 1'b1, 1'b0, 2'b00);
        mdu_wait(cnt);
        chk("stall_busy_cycles", 64'(cnt), 64'd33);
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_busy", 64'(busy_e), 64'd0);
            bubble_check("stall_hold");
            chk("stall_result_held", 64'(alu_result_m), 64'd0);
        end
        stall_m = 1'b0;
        @(negedge clk);
        pop_check("mul_after_stall");
        valid_e = 1'b0;
        @(negedge clk);
        bubble_check("after_stall_once");
        chk("after_stall_busy", 64'(busy_e), 64'd0);
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
